kp_scan_ctrl: RTL and testbench

//  Scanning controller for a 4x4 matrix keypad. Drives one-cold column strobes and samples synchronised row inputs.

---
 rtl/kp_pkg.sv | 11 +
 rtl/kp_tick_gen.sv | 16 +
 rtl/kp_scan_ctrl.sv | 82 ++++++++
 tb/tb_kp_scan_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// kp_pkg: shared state encoding, keypad geometry and row/column encoders for the keypad scanner
package kp_pkg;
  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2, RELEASED = 2'd3} kp_state_t;
  localparam int KP_NROW = 4;
  localparam int KP_NCOL = 4;
  localparam int KP_CODE_W = 4;
  localparam logic [KP_NCOL-1:0] COL_RESET = 4'b1110;
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/kp_tick_gen.sv
// kp_tick_gen: column dwell counter, one-cycle tick at SCAN_DIV-1, restarts on clr
module kp_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/kp_scan_ctrl.sv
// kp_scan_ctrl: 4x4 keypad scanner with press/release debounce and load pulse on release
// Optional auto-repeat load pulses while a key is held: define KP_AUTOREPEAT_EN
module kp_scan_ctrl
  import kp_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DB_CNT       = 4,
  parameter int REPEAT_TICKS = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KP_NROW-1:0]   row,
  output logic [KP_NCOL-1:0]   col,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 pressed,
  output logic                 load
);
  localparam int DW = $clog2(DB_CNT + 1);
  logic [KP_NROW-1:0] row_m, row_s;
  kp_state_t state, state_n;
  logic [1:0] row_idx;
  logic [DW-1:0] db, db_inc;
  logic tick, held, hit, rotate, db_done, rep_fire;
  assign held    = !row_s[row_idx];
  assign hit     = row_s != '1;
  assign db_inc  = db + 1'b1;
  assign db_done = db_inc == DW'(DB_CNT);
  assign rotate  = (state == SCAN && tick && !hit) || (state == DEBOUNCE && tick && !held) || state == RELEASED;
  kp_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (rotate),
    .tick (tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SCAN;
    else state <= state_n;
  always_comb begin
    state_n = state == SCAN     ? (tick && hit ? DEBOUNCE : SCAN) :
              state == DEBOUNCE ? (!tick ? DEBOUNCE : !held ? SCAN : db_done ? PRESSED : DEBOUNCE) :
              state == PRESSED  ? (tick && !held && db_done ? RELEASED : PRESSED) : SCAN;
  end
  always_comb begin
    pressed = state == PRESSED;
    load    = state == RELEASED || rep_fire;
  end
  // the column stays frozen outside SCAN, so col itself identifies the key's column
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col      <= COL_RESET;
      row_idx  <= '0;
      db       <= '0;
      key_code <= '0;
    end else begin
      if (rotate) col <= {col[KP_NCOL-2:0], col[KP_NCOL-1]};
      if (state == SCAN && tick && hit) begin
        row_idx <= low_idx(row_s);
        db      <= DW'(1);
      end else if (tick && state == DEBOUNCE) db <= (held && !db_done) ? db_inc : '0;
      else if (tick && state == PRESSED) db <= (!held && !db_done) ? db_inc : '0;
      if (state == DEBOUNCE && tick && held && db_done) key_code <= {row_idx, low_idx(col)};
    end
`ifdef KP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep;
  assign rep_fire = state == PRESSED && tick && held && rep == RW'(REPEAT_TICKS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) rep <= '0;
    else if (state != PRESSED) rep <= '0;
    else if (tick) rep <= (held && !rep_fire) ? rep + 1'b1 : '0;
`else
  assign rep_fire = REPEAT_TICKS < 0;
`endif
endmodule

// File: tb/tb_kp_scan_ctrl.sv
// tb_kp_scan_ctrl: keypad matrix model, vector table and load scoreboard for kp_scan_ctrl
module tb_kp_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic pressed, load;
  logic [15:0] keys = '0;
  int total = 0;
  int bad = 0;
  logic [3:0] sb[$];
  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;
  vec_t vt[6];
  kp_scan_ctrl #(.SCAN_DIV(4), .DB_CNT(3), .REPEAT_TICKS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .pressed  (pressed),
    .load     (load)
  );
  always #5 clk = ~clk;
  // key r*4+c shorts row r to column c
  always_comb begin
    row = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    nclk(2);
    rst = 1'b0;
  endtask
  task automatic wait_pressed(input logic v, input string n);
    int i = 0;
    while (pressed !== v && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(n, pressed, v);
  endtask
  task automatic wait_drain(input string n);
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk(n, sb.size(), 0);
  endtask
  always @(negedge clk)
    if (!rst && load) begin
      if (sb.size() == 0) chk("spurious_load", load, 1'b0);
      else chk("load_code", key_code, sb.pop_front());
    end
  initial begin
    vt[0] = '{16'h0200, 4'd9};
    vt[1] = '{16'h0001, 4'd0};
    vt[2] = '{16'h8000, 4'd15};
    vt[3] = '{16'h0040, 4'd6};
    vt[4] = '{16'h1000, 4'd12};
    vt[5] = '{16'h8008, 4'd3};
    nclk(1);
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 4'd0);
    chk("rst_pressed", pressed, 1'b0);
    chk("rst_load", load, 1'b0);
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((k / 4) % 4));
      chk("idle_col", col, ec);
      nclk(1);
    end
    for (int i = 0; i < 6; i++) begin
      keys = vt[i].keys;
      wait_pressed(1'b1, "vec_press");
      chk("vec_code", key_code, vt[i].code);
      sb.push_back(vt[i].code);
      keys = '0;
      wait_drain("vec_release_load");
      chk("vec_unpressed", pressed, 1'b0);
      chk("vec_code_hold", key_code, vt[i].code);
      nclk(8);
    end
    keys = 16'h8008;
    wait_pressed(1'b1, "dual_press");
    chk("dual_code", key_code, 4'd3);
`ifdef KP_AUTOREPEAT_EN
    sb.push_back(4'd3);
`endif
    keys = 16'h0008;
    nclk(24);
    chk("dual_row3_release", pressed, 1'b1);
    sb.push_back(4'd3);
    keys = '0;
    wait_drain("dual_release_load");
    reset_dut();
    keys = 16'h0010;
    nclk(4);
    keys = '0;
    nclk(6);
    chk("bounce_col", col, 4'b1101);
    chk("bounce_pressed", pressed, 1'b0);
    nclk(3);
    chk("bounce_next_col", col, 4'b1011);
    nclk(30);
    chk("bounce_no_press", pressed, 1'b0);
`ifdef KP_AUTOREPEAT_EN
    keys = 16'h0200;
    wait_pressed(1'b1, "ar_press");
    sb.push_back(4'd9);
    sb.push_back(4'd9);
    nclk(48);
    chk("ar_repeats", sb.size(), 0);
    sb.push_back(4'd9);
    keys = '0;
    wait_drain("ar_release_load");
`endif
    keys = 16'h0200;
    wait_pressed(1'b1, "mid_press");
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_code", key_code, 4'd0);
    chk("mid_rst_pressed", pressed, 1'b0);
    chk("mid_rst_load", load, 1'b0);
    keys = '0;
    nclk(2);
    rst = 1'b0;
    nclk(3);
    chk("post_rst_col3", col, 4'b1110);
    nclk(1);
    chk("post_rst_col4", col, 4'b1101);
    nclk(40);
    chk("post_rst_pressed", pressed, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
